// File: rtl/ch0re_ex_resolve.sv
// Execute-stage back end: resolves branches/jumps, issues a one-cycle fetch redirect,
// and registers the instruction into EX/MEM through a 2-entry skid buffer.
module ch0re_ex_resolve #(
    parameter int XLEN  = 64,
    parameter int RegAw = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_alu_res,
    input  logic             i_flag_zero,
    input  logic             i_flag_less,
    input  logic [1:0]       i_kind,
    input  logic [2:0]       i_br_cond,
    input  logic [RegAw-1:0] i_rd,
    input  logic             i_rd_we,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_res,
    output logic [RegAw-1:0] o_rd,
    output logic             o_rd_we,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_misalign
);

    typedef enum logic [1:0] {
        KindAlu    = 2'd0,
        KindBranch = 2'd1,
        KindJal    = 2'd2,
        KindJalr   = 2'd3
    } kind_e;

    kind_e            w_kind;
    logic             w_accept;
    logic             w_retire;
    logic             w_mainFree;
    logic             w_skidValidNext;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_res;
    logic             w_rdWe;
    logic [XLEN-1:0]  w_link;

    logic             r_ready;
    logic             r_mainValid;
    logic [XLEN-1:0]  r_mainRes;
    logic [RegAw-1:0] r_mainRd;
    logic             r_mainRdWe;
    logic             r_skidValid;
    logic [XLEN-1:0]  r_skidRes;
    logic [RegAw-1:0] r_skidRd;
    logic             r_skidRdWe;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirectPc;
    logic             r_misalign;

    assign w_kind     = kind_e'(i_kind);
    assign w_accept   = i_valid & r_ready & ~i_flush;
    assign w_retire   = r_mainValid & i_ready;
    assign w_mainFree = ~r_mainValid | w_retire;
    assign w_link     = i_pc + XLEN'(4);

    // Skid only stays/becomes occupied while main is still holding an unretired entry.
    assign w_skidValidNext = ~i_flush & ~w_mainFree & (r_skidValid | w_accept);

    always_comb begin
        w_taken  = 1'b0;
        w_target = i_pc + i_imm;
        w_res    = i_alu_res;
        w_rdWe   = i_rd_we & (i_rd != '0);
        case (w_kind)
            KindBranch: begin
                w_rdWe = 1'b0;
                case (i_br_cond)
                    3'd0:       w_taken = i_flag_zero;
                    3'd1:       w_taken = ~i_flag_zero;
                    3'd4, 3'd6: w_taken = i_flag_less;
                    3'd5, 3'd7: w_taken = ~i_flag_less;
                    default:    w_taken = 1'b0;
                endcase
            end
            KindJal: begin
                w_taken = 1'b1;
                w_res   = w_link;
            end
            KindJalr: begin
                w_taken  = 1'b1;
                w_res    = w_link;
                w_target = i_alu_res & ~XLEN'(1);
            end
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready      <= 1'b0;
            r_mainValid  <= 1'b0;
            r_mainRes    <= '0;
            r_mainRd     <= '0;
            r_mainRdWe   <= 1'b0;
            r_skidValid  <= 1'b0;
            r_skidRes    <= '0;
            r_skidRd     <= '0;
            r_skidRdWe   <= 1'b0;
            r_redirect   <= 1'b0;
            r_redirectPc <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_ready    <= ~w_skidValidNext;
            r_redirect <= w_accept & w_taken;
            r_misalign <= w_accept & w_taken & (w_target[1:0] != 2'b00);
            if (w_accept & w_taken) begin
                r_redirectPc <= w_target;
            end
            if (i_flush) begin
                r_mainValid <= 1'b0;
                r_skidValid <= 1'b0;
            end else if (w_mainFree) begin
                // Skid is older than anything arriving now, so it always wins main.
                if (r_skidValid) begin
                    r_mainValid <= 1'b1;
                    r_mainRes   <= r_skidRes;
                    r_mainRd    <= r_skidRd;
                    r_mainRdWe  <= r_skidRdWe;
                    r_skidValid <= 1'b0;
                end else begin
                    r_mainValid <= w_accept;
                    if (w_accept) begin
                        r_mainRes  <= w_res;
                        r_mainRd   <= i_rd;
                        r_mainRdWe <= w_rdWe;
                    end
                end
            end else if (w_accept) begin
                r_skidValid <= 1'b1;
                r_skidRes   <= w_res;
                r_skidRd    <= i_rd;
                r_skidRdWe  <= w_rdWe;
            end
        end
    end

    assign o_ready       = r_ready;
    assign o_valid       = r_mainValid;
    assign o_res         = r_mainRes;
    assign o_rd          = r_mainRd;
    assign o_rd_we       = r_mainRdWe;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirectPc;
    assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_ch0re_ex_resolve.sv
// Directed self-checking bench for ch0re_ex_resolve: hand-computed vectors
// covering ALU streaming, branch/jump resolution, backpressure, flush and reset.
module tb_ch0re_ex_resolve;

    localparam int XLEN  = 64;
    localparam int RegAw = 5;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_imm;
    logic [XLEN-1:0]  i_alu_res;
    logic             i_flag_zero;
    logic             i_flag_less;
    logic [1:0]       i_kind;
    logic [2:0]       i_br_cond;
    logic [RegAw-1:0] i_rd;
    logic             i_rd_we;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_res;
    logic [RegAw-1:0] o_rd;
    logic             o_rd_we;
    logic             o_redirect;
    logic [XLEN-1:0]  o_redirect_pc;
    logic             o_misalign;

    int assertCount = 0;
    int failCount   = 0;

    ch0re_ex_resolve #(.XLEN(XLEN), .RegAw(RegAw)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_alu_res     (i_alu_res),
        .i_flag_zero   (i_flag_zero),
        .i_flag_less   (i_flag_less),
        .i_kind        (i_kind),
        .i_br_cond     (i_br_cond),
        .i_rd          (i_rd),
        .i_rd_we       (i_rd_we),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_res         (o_res),
        .o_rd          (o_rd),
        .o_rd_we       (o_rd_we),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc),
        .o_misalign    (o_misalign)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] cond,
                                 input logic [63:0] pc, input logic [63:0] imm,
                                 input logic [63:0] alu, input logic zero, input logic less,
                                 input logic [4:0] rd, input logic rdWe);
        i_valid     = 1'b1;
        i_kind      = kind;
        i_br_cond   = cond;
        i_pc        = pc;
        i_imm       = imm;
        i_alu_res   = alu;
        i_flag_zero = zero;
        i_flag_less = less;
        i_rd        = rd;
        i_rd_we     = rdWe;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_pc = '0; i_imm = '0; i_alu_res = '0;
        i_flag_zero = 1'b0; i_flag_less = 1'b0;
        i_kind = 2'd0; i_br_cond = 3'd0; i_rd = '0; i_rd_we = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_ready", 64'(o_ready), 64'd0);
        checkOutput("rst_redirect", 64'(o_redirect), 64'd0);
        checkOutput("rst_redirect_pc", o_redirect_pc, 64'd0);
        #10 i_rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", 64'(o_ready), 64'd1);

        // ALU stream, back-to-back
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(2'd0, 3'd0, 64'h10 * k, 64'd0, 64'(k), 1'b0, 1'b0, 5'd3, 1'b1);
            tick();
            checkOutput($sformatf("alu%0d_valid", k), 64'(o_valid), 64'd1);
            checkOutput($sformatf("alu%0d_res", k), o_res, 64'(k));
            checkOutput($sformatf("alu%0d_redirect", k), 64'(o_redirect), 64'd0);
        end
        i_valid = 1'b0;
        tick();
        checkOutput("alu_drain_valid", 64'(o_valid), 64'd0);

        // BEQ taken, then not taken
        applyStimulus(2'd1, 3'd0, 64'h100, 64'h20, 64'h0, 1'b1, 1'b0, 5'd5, 1'b1);
        tick();
        checkOutput("beq_redirect", 64'(o_redirect), 64'd1);
        checkOutput("beq_target", o_redirect_pc, 64'h120);
        checkOutput("beq_rd_we", 64'(o_rd_we), 64'd0);
        checkOutput("beq_misalign", 64'(o_misalign), 64'd0);
        i_valid = 1'b0;
        tick();
        checkOutput("beq_pulse_end", 64'(o_redirect), 64'd0);
        checkOutput("beq_pc_hold", o_redirect_pc, 64'h120);
        applyStimulus(2'd1, 3'd0, 64'h100, 64'h20, 64'h5, 1'b0, 1'b0, 5'd5, 1'b1);
        tick();
        checkOutput("beq_nt_redirect", 64'(o_redirect), 64'd0);
        checkOutput("beq_nt_valid", 64'(o_valid), 64'd1);

        // BGEU less=1 not taken, BLTU less=1 taken, cond 2 not taken
        applyStimulus(2'd1, 3'd7, 64'h300, 64'h40, 64'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        checkOutput("bgeu_redirect", 64'(o_redirect), 64'd0);
        applyStimulus(2'd1, 3'd6, 64'h300, 64'h40, 64'h0, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        checkOutput("bltu_redirect", 64'(o_redirect), 64'd1);
        checkOutput("bltu_target", o_redirect_pc, 64'h340);
        applyStimulus(2'd1, 3'd2, 64'h500, 64'h40, 64'h0, 1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        checkOutput("cond2_redirect", 64'(o_redirect), 64'd0);

        // JALR misaligned target, JAL to x0
        applyStimulus(2'd3, 3'd0, 64'h200, 64'h0, 64'h1003, 1'b0, 1'b0, 5'd1, 1'b1);
        tick();
        checkOutput("jalr_res", o_res, 64'h204);
        checkOutput("jalr_target", o_redirect_pc, 64'h1002);
        checkOutput("jalr_misalign", 64'(o_misalign), 64'd1);
        checkOutput("jalr_rd_we", 64'(o_rd_we), 64'd1);
        applyStimulus(2'd2, 3'd0, 64'h400, 64'h10, 64'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        checkOutput("jal_rd_we", 64'(o_rd_we), 64'd0);
        checkOutput("jal_res", o_res, 64'h404);
        checkOutput("jal_target", o_redirect_pc, 64'h410);
        checkOutput("jal_misalign", 64'(o_misalign), 64'd0);
        i_valid = 1'b0;
        tick();

        // Backpressure: A to main, B to skid, C held off, then drain in order
        i_ready = 1'b0;
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'hA, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        checkOutput("bp_a_ready", 64'(o_ready), 64'd1);
        checkOutput("bp_a_res", o_res, 64'hA);
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'hB, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        checkOutput("bp_b_ready", 64'(o_ready), 64'd0);
        checkOutput("bp_b_hold", o_res, 64'hA);
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'hC, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        checkOutput("bp_c_ready", 64'(o_ready), 64'd0);
        checkOutput("bp_c_hold", o_res, 64'hA);
        i_ready = 1'b1;
        tick();
        checkOutput("bp_drain_b", o_res, 64'hB);
        checkOutput("bp_drain_ready", 64'(o_ready), 64'd1);
        tick();
        checkOutput("bp_drain_c", o_res, 64'hC);
        checkOutput("bp_drain_c_valid", 64'(o_valid), 64'd1);
        i_valid = 1'b0;
        tick();
        checkOutput("bp_empty", 64'(o_valid), 64'd0);

        // Flush with a taken BNE offered the same cycle
        i_ready = 1'b0;
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'h11, 1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        applyStimulus(2'd1, 3'd1, 64'h600, 64'h8, 64'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        i_flush = 1'b1;
        tick();
        checkOutput("flush1_valid", 64'(o_valid), 64'd0);
        checkOutput("flush1_redirect", 64'(o_redirect), 64'd0);
        i_flush = 1'b0;
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'h21, 1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        applyStimulus(2'd0, 3'd0, 64'h0, 64'h0, 64'h22, 1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        checkOutput("flush2_full_ready", 64'(o_ready), 64'd0);
        applyStimulus(2'd1, 3'd1, 64'h600, 64'h8, 64'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        i_flush = 1'b1;
        tick();
        checkOutput("flush2_valid", 64'(o_valid), 64'd0);
        checkOutput("flush2_redirect", 64'(o_redirect), 64'd0);
        checkOutput("flush2_ready", 64'(o_ready), 64'd1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        checkOutput("flush2_no_ghost", 64'(o_valid), 64'd0);

        // Asynchronous reset mid-stream with a pending redirect
        applyStimulus(2'd2, 3'd0, 64'h700, 64'h2, 64'h0, 1'b0, 1'b0, 5'd6, 1'b1);
        tick();
        checkOutput("prerst_redirect", 64'(o_redirect), 64'd1);
        checkOutput("prerst_misalign", 64'(o_misalign), 64'd1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(o_valid), 64'd0);
        checkOutput("midrst_redirect", 64'(o_redirect), 64'd0);
        checkOutput("midrst_misalign", 64'(o_misalign), 64'd0);
        checkOutput("midrst_res", o_res, 64'd0);
        checkOutput("midrst_redirect_pc", o_redirect_pc, 64'd0);
        checkOutput("midrst_ready", 64'(o_ready), 64'd0);
        i_valid = 1'b0;
        #2 i_rst_n = 1'b1;
        tick();
        checkOutput("rerst_ready", 64'(o_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
